// File: rtl/pic_cmd_writer.sv
// PIC command writer: captures CPU write cycles, decodes the ICW1-ICW4
// initialisation sequence and OCW1/OCW2/OCW3, and drives mask/IRR/ISR
// read-back onto the data bus.
//
// Bus handshake: a write is the low pulse of WR_n. Every edge that sees
// WR_n=0 with CS_n=0 captures A0/D_in into holding registers. The command
// commits on the first edge that sees WR_n high again after a captured
// pulse. A read is CS_n=0, RD_n=0, WR_n=1 at an edge; the data appears
// registered on the following cycle. There is no back-pressure.
module pic_cmd_writer #(
   parameter logic [7:0] RESET_MASK = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       CS_n,
   input  logic       WR_n,
   input  logic       RD_n,
   input  logic       A0,
   input  logic [7:0] D_in,
   input  logic [7:0] irr,
   input  logic [7:0] isr,
   output logic [7:0] cur_MASK,
   output logic       MASK_reset,
   output logic [7:0] D_out,
   output logic       D_out_en,
   output logic       init_done,
   output logic [4:0] vector_base,
   output logic       sngl,
   output logic       ic4,
   output logic [7:0] icw3,
   output logic [7:0] icw4,
   output logic       ocw2_valid,
   output logic [7:0] ocw2_data
);

   typedef enum logic [2:0] {
      WAIT_ICW1,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } state_t;

   state_t     state;
   logic       wr_q;
   logic       wr_active;
   logic       a0_h;
   logic [7:0] d_h;
   logic       read_isr;
   logic       commit;
   logic       rd_cycle;

   // A captured write commits once, on the first edge WR_n is seen high again.
   assign commit   = WR_n && !wr_q && wr_active;
   assign rd_cycle = !CS_n && !RD_n && WR_n;

   // Write capture: hold the last selected A0/D_in of the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= 1'b1;
         wr_active <= 1'b0;
         a0_h      <= 1'b0;
         d_h       <= 8'h00;
      end else begin
         wr_q <= WR_n;
         if (!WR_n && !CS_n) begin
            a0_h      <= A0;
            d_h       <= D_in;
            wr_active <= 1'b1;
         end else if (commit) begin
            wr_active <= 1'b0;
         end
      end
   end

   // Command decode FSM with registered outputs; pulses default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_ICW1;
         cur_MASK    <= RESET_MASK;
         MASK_reset  <= 1'b0;
         ocw2_valid  <= 1'b0;
         init_done   <= 1'b0;
         vector_base <= 5'h00;
         sngl        <= 1'b0;
         ic4         <= 1'b0;
         icw3        <= 8'h00;
         icw4        <= 8'h00;
         ocw2_data   <= 8'h00;
         read_isr    <= 1'b0;
      end else begin
         MASK_reset <= 1'b0;
         ocw2_valid <= 1'b0;
         if (commit) begin
            if (!a0_h && d_h[4]) begin
               // ICW1 restarts initialisation from any state.
               sngl       <= d_h[1];
               ic4        <= d_h[0];
               cur_MASK   <= RESET_MASK;
               MASK_reset <= 1'b1;
               init_done  <= 1'b0;
               read_isr   <= 1'b0;
               state      <= WAIT_ICW2;
            end else begin
               case (state)
                  WAIT_ICW2: begin
                     if (a0_h) begin
                        vector_base <= d_h[7:3];
                        if (!sngl) begin
                           state <= WAIT_ICW3;
                        end else if (ic4) begin
                           state <= WAIT_ICW4;
                        end else begin
                           state     <= READY;
                           init_done <= 1'b1;
                        end
                     end
                  end
                  WAIT_ICW3: begin
                     if (a0_h) begin
                        icw3 <= d_h;
                        if (ic4) begin
                           state <= WAIT_ICW4;
                        end else begin
                           state     <= READY;
                           init_done <= 1'b1;
                        end
                     end
                  end
                  WAIT_ICW4: begin
                     if (a0_h) begin
                        icw4      <= d_h;
                        state     <= READY;
                        init_done <= 1'b1;
                     end
                  end
                  READY: begin
                     if (a0_h) begin
                        cur_MASK <= d_h;
                     end else if (!d_h[3]) begin
                        ocw2_data  <= d_h;
                        ocw2_valid <= 1'b1;
                     end else if (d_h[1]) begin
                        read_isr <= d_h[0];
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   // Registered read-back; D_out holds its last value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D_out    <= 8'h00;
         D_out_en <= 1'b0;
      end else begin
         D_out_en <= rd_cycle;
         if (rd_cycle) begin
            D_out <= A0 ? cur_MASK : (read_isr ? isr : irr);
         end
      end
   end

endmodule

// File: tb/tb_pic_cmd_writer.sv
// Testbench for pic_cmd_writer: directed sequences plus randomized bus
// cycles, compared against a behavioural model of the command rules.
module tb_pic_cmd_writer;

   logic       clk;
   logic       rst_n;
   logic       CS_n;
   logic       WR_n;
   logic       RD_n;
   logic       A0;
   logic [7:0] D_in;
   logic [7:0] irr;
   logic [7:0] isr;
   logic [7:0] cur_MASK;
   logic       MASK_reset;
   logic [7:0] D_out;
   logic       D_out_en;
   logic       init_done;
   logic [4:0] vector_base;
   logic       sngl;
   logic       ic4;
   logic [7:0] icw3;
   logic [7:0] icw4;
   logic       ocw2_valid;
   logic [7:0] ocw2_data;

   int errors = 0;
   int checks = 0;

   pic_cmd_writer #(.RESET_MASK(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
      .A0(A0), .D_in(D_in), .irr(irr), .isr(isr), .cur_MASK(cur_MASK),
      .MASK_reset(MASK_reset), .D_out(D_out), .D_out_en(D_out_en),
      .init_done(init_done), .vector_base(vector_base), .sngl(sngl),
      .ic4(ic4), .icw3(icw3), .icw4(icw4), .ocw2_valid(ocw2_valid),
      .ocw2_data(ocw2_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Phases of initialisation: 1 = expect ICW1, 2..4 = expect ICWn, 5 = ready.
   int         m_phase;
   logic [7:0] m_mask;
   logic       m_init;
   logic [4:0] m_vb;
   logic       m_sngl;
   logic       m_ic4;
   logic [7:0] m_icw3;
   logic [7:0] m_icw4;
   logic [7:0] m_ocw2;
   logic       m_sel_isr;
   logic [7:0] m_dout;
   logic       m_mreset;
   logic       m_ocw2v;

   task automatic model_reset();
      m_phase = 1; m_mask = 8'h00; m_init = 0; m_vb = 0; m_sngl = 0;
      m_ic4 = 0; m_icw3 = 0; m_icw4 = 0; m_ocw2 = 0; m_sel_isr = 0;
      m_dout = 0; m_mreset = 0; m_ocw2v = 0;
   endtask

   // Which ICW comes after the current one, given the ICW1 flags.
   function automatic int after_icw(int cur);
      int nxt;
      nxt = cur + 1;
      if (nxt == 3 && m_sngl) nxt = 4;
      if (nxt == 4 && !m_ic4) nxt = 5;
      return nxt;
   endfunction

   task automatic model_write(input logic a0, input logic [7:0] d);
      if (!a0 && d[4]) begin
         m_sngl = d[1]; m_ic4 = d[0]; m_mask = 8'h00; m_mreset = 1;
         m_init = 0; m_sel_isr = 0; m_phase = 2;
      end else if (a0 && m_phase == 2) begin
         m_vb = d[7:3]; m_phase = after_icw(2);
      end else if (a0 && m_phase == 3) begin
         m_icw3 = d; m_phase = after_icw(3);
      end else if (a0 && m_phase == 4) begin
         m_icw4 = d; m_phase = 5;
      end else if (m_phase == 5) begin
         if (a0) m_mask = d;
         else if (!d[3]) begin m_ocw2 = d; m_ocw2v = 1; end
         else if (d[1]) m_sel_isr = d[0];
      end
      if (m_phase == 5) m_init = 1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mask"},   32'(cur_MASK),    32'(m_mask));
      chk({tag, ".mreset"}, 32'(MASK_reset),  32'(m_mreset));
      chk({tag, ".init"},   32'(init_done),   32'(m_init));
      chk({tag, ".vb"},     32'(vector_base), 32'(m_vb));
      chk({tag, ".sngl"},   32'(sngl),        32'(m_sngl));
      chk({tag, ".ic4"},    32'(ic4),         32'(m_ic4));
      chk({tag, ".icw3"},   32'(icw3),        32'(m_icw3));
      chk({tag, ".icw4"},   32'(icw4),        32'(m_icw4));
      chk({tag, ".ocw2v"},  32'(ocw2_valid),  32'(m_ocw2v));
      chk({tag, ".ocw2"},   32'(ocw2_data),   32'(m_ocw2));
      chk({tag, ".dout"},   32'(D_out),       32'(m_dout));
      chk({tag, ".den"},    32'(D_out_en),    32'd0);
   endtask

   // ---------------- drivers ----------------
   // One write strobe held low for `hold` cycles, then `idle` quiet cycles
   // in which the one-cycle pulses must stay low.
   task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                           input logic cs_on, input logic rd_on,
                           input int hold, input int idle);
      @(negedge clk);
      CS_n = !cs_on; WR_n = 0; RD_n = !rd_on; A0 = a0; D_in = d;
      repeat (hold) begin
         @(negedge clk);
         chk({tag, ".den_wr"}, 32'(D_out_en), 32'd0);
      end
      WR_n = 1; CS_n = 1; RD_n = 1;
      A0 = 1'($urandom); D_in = 8'($urandom);
      @(negedge clk);
      if (cs_on) model_write(a0, d);
      check_all(tag);
      m_mreset = 0; m_ocw2v = 0;
      repeat (idle) begin
         @(negedge clk);
         chk({tag, ".mreset_idle"}, 32'(MASK_reset), 32'd0);
         chk({tag, ".ocw2v_idle"},  32'(ocw2_valid), 32'd0);
      end
   endtask

   task automatic do_read(input string tag, input logic a0,
                          input logic [7:0] irr_v, input logic [7:0] isr_v);
      @(negedge clk);
      CS_n = 0; RD_n = 0; A0 = a0; irr = irr_v; isr = isr_v;
      m_dout = a0 ? m_mask : (m_sel_isr ? isr_v : irr_v);
      @(negedge clk);
      chk({tag, ".den"},  32'(D_out_en), 32'd1);
      chk({tag, ".dout"}, 32'(D_out),    32'(m_dout));
      CS_n = 1; RD_n = 1; irr = 8'($urandom); isr = 8'($urandom);
      @(negedge clk);
      chk({tag, ".den_off"}, 32'(D_out_en), 32'd0);
      chk({tag, ".dout_hold"}, 32'(D_out), 32'(m_dout));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 0; CS_n = 1; WR_n = 1; RD_n = 1; A0 = 0; D_in = 0;
      irr = 0; isr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      rst_n = 1;

      // ICW1 single + ic4, ICW2, ICW4
      do_write("icw1_a", 0, 8'h13, 1, 0, 1, 2);
      do_write("icw2_a", 1, 8'h40, 1, 0, 2, 1);
      do_write("icw4_a", 1, 8'h01, 1, 0, 1, 1);
      chk("seq_a.vb", 32'(vector_base), 32'h08);
      chk("seq_a.init", 32'(init_done), 32'd1);

      // Cascade sequence then OCW1
      do_write("icw1_b", 0, 8'h11, 1, 0, 1, 1);
      do_write("icw2_b", 1, 8'h20, 1, 0, 1, 1);
      do_write("icw3_b", 1, 8'h04, 1, 0, 3, 1);
      do_write("icw4_b", 1, 8'h01, 1, 0, 1, 1);
      do_write("ocw1_b", 1, 8'hF0, 1, 0, 1, 2);
      chk("seq_b.mask", 32'(cur_MASK), 32'hF0);

      // Read-back paths
      do_read("rd_mask", 1, 8'h00, 8'h00);
      do_write("ocw3_isr", 0, 8'h0B, 1, 0, 1, 1);
      do_read("rd_isr", 0, 8'h33, 8'h05);
      do_write("ocw3_irr", 0, 8'h0A, 1, 0, 1, 1);
      do_read("rd_irr", 0, 8'h81, 8'h05);
      do_write("ocw3_nop", 0, 8'h09, 1, 0, 1, 1);
      do_read("rd_irr2", 0, 8'h42, 8'h24);

      // Restart while waiting for ICW4
      do_write("icw1_c", 0, 8'h13, 1, 0, 1, 1);
      do_write("icw2_c", 1, 8'h48, 1, 0, 1, 1);
      do_write("icw1_mid", 0, 8'h13, 1, 0, 1, 2);
      do_write("ign_a0lo", 0, 8'h00, 1, 0, 1, 1);
      do_write("icw2_mid", 1, 8'hA8, 1, 0, 1, 1);

      // Asynchronous reset between ICW2 and ICW4
      @(posedge clk);
      #3 rst_n = 0;
      #1 model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1;
      do_write("post_rst", 1, 8'h55, 1, 0, 1, 1);

      // OCW2 pulse with long WR_n high afterwards, then unselected write
      do_write("icw1_d", 0, 8'h12, 1, 0, 1, 1);
      do_write("icw2_d", 1, 8'h30, 1, 0, 1, 1);
      do_write("ocw2_d", 0, 8'h20, 1, 0, 1, 5);
      do_write("cs_off", 1, 8'hAA, 0, 0, 2, 1);
      do_write("wr_rd", 1, 8'h3C, 1, 1, 2, 1);

      // Randomized bus cycles
      for (int i = 0; i < 80; i++) begin
         int op;
         logic [7:0] d;
         op = $urandom_range(0, 9);
         d  = 8'($urandom);
         if (op < 2) do_write("r_icw1", 0, d | 8'h10, 1, 0, $urandom_range(1, 3), $urandom_range(0, 2));
         else if (op < 6) do_write("r_wr", 1'($urandom), d, ($urandom_range(0, 7) != 0), 1'($urandom),
                                   $urandom_range(1, 3), $urandom_range(0, 2));
         else if (op < 8) do_write("r_ocw", 0, d & 8'hEF, 1, 0, $urandom_range(1, 3), $urandom_range(0, 2));
         else do_read("r_rd", 1'($urandom), 8'($urandom), 8'($urandom));
      end

      @(negedge clk);
      check_all("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pic_cmd_writer.md
Name: pic_cmd_writer

Overview:
- Write/read command front end of the PIC control logic; generates `cur_MASK` and `MASK_reset` for the interrupt mask register from CPU bus cycles, and reads IMR/IRR/ISR back onto the bus.
- Decodes the ICW1–ICW4 initialisation sequence and OCW1/OCW2/OCW3 from 8-bit writes qualified by `CS_n`, `WR_n` and `A0`.
- Drives the read-back data bus from `RD_n`.

Parameters:
- RESET_MASK, 8'h00, value loaded into `cur_MASK` on reset and on every ICW1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- CS_n  input  1  chip select, active low.
- WR_n  input  1  write strobe, active low.
- RD_n  input  1  read strobe, active low.
- A0  input  1  address bit.
- D_in  input  8  CPU write data.
- irr  input  8  interrupt request register, for read-back.
- isr  input  8  in-service register, for read-back.
- cur_MASK  output  8  mask value sent to the IMR.
- MASK_reset  output  1  one-cycle pulse that clears the IMR.
- D_out  output  8  read-back data.
- D_out_en  output  1  bus drive enable.
- init_done  output  1  high once the ICW sequence is complete.
- vector_base  output  5  ICW2 D[7:3].
- sngl  output  1  ICW1 D1.
- ic4  output  1  ICW1 D0.
- icw3  output  8  cascade byte.
- icw4  output  8  mode byte.
- ocw2_valid  output  1  one-cycle pulse when an OCW2 is written.
- ocw2_data  output  8  last OCW2 byte.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=WAIT_ICW1, `cur_MASK`=RESET_MASK.
  - `MASK_reset`=0, `ocw2_valid`=0, `init_done`=0.
  - `vector_base`/`sngl`/`ic4`/`icw3`/`icw4`/`ocw2_data`=0.
  - Read select = IRR.
  - `D_out`=0, `D_out_en`=0.
  - `wr_q`=1, `wr_active`=0.
- Write capture:
  - Each clk edge with WR_n=0 and CS_n=0: latch A0 and D_in into holding registers, set `wr_active`.
  - `wr_q` is WR_n registered.
  - Commit occurs at the clk edge where WR_n=1, `wr_q`=0 and `wr_active`=1; that edge also clears `wr_active`.
  - Committed effects are visible one cycle after WR_n is first sampled high.
  - WR_n rising with CS_n never low during the pulse does nothing.
- Decode at commit (h = held byte):
  - ICW1 = A0=0, h[4]=1. Accepted in any state, including mid-sequence, which restarts initialisation.
    - `sngl`=h[1], `ic4`=h[0].
    - `cur_MASK`=RESET_MASK, `MASK_reset`=1 for exactly one cycle.
    - `init_done`=0, read select=IRR.
    - state=WAIT_ICW2.
  - WAIT_ICW2, A0=1: `vector_base`=h[7:3]. Next state:
    - WAIT_ICW3 if `sngl`=0;
    - else WAIT_ICW4 if `ic4`=1;
    - else READY.
  - WAIT_ICW3, A0=1: `icw3`=h. Next state WAIT_ICW4 if `ic4`=1, else READY.
  - WAIT_ICW4, A0=1: `icw4`=h. Next state READY.
  - Entering READY sets `init_done`=1.
  - In WAIT_ICW2/3/4, any A0=0 write other than ICW1 is ignored.
  - In WAIT_ICW1, non-ICW1 writes are ignored.
  - READY, A0=1 (OCW1): `cur_MASK`=h. `MASK_reset` stays 0.
  - READY, A0=0, h[4]=0, h[3]=0 (OCW2): `ocw2_data`=h, `ocw2_valid`=1 for one cycle.
  - READY, A0=0, h[4]=0, h[3]=1 (OCW3): if h[1]=1, read select = h[0] ? ISR : IRR. If h[1]=0, no change.
- Read path (registered, 1-cycle latency):
  - `D_out_en`=1 when CS_n=0, RD_n=0 and WR_n=1 were sampled on the previous edge.
  - `D_out` = `cur_MASK` if A0=1; otherwise `isr` or `irr` per read select.
  - `D_out` updates each enabled cycle.
  - Reads never alter state.
  - RD_n and WR_n both low: write capture proceeds, `D_out_en`=0.
- Pulses `MASK_reset` and `ocw2_valid` never exceed one cycle, regardless of how long WR_n is held high.

Test Plan:
- Reset then ICW1=8'h13 (`sngl`=1, `ic4`=1), ICW2=8'h40, ICW4=8'h01 -> `MASK_reset` pulses 1 cycle after ICW1 commit; `cur_MASK`=8'h00; `vector_base`=5'h08; `icw4`=8'h01; `init_done`=1; `icw3` unchanged at 0.
- Sequence ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01, then OCW1=8'hF0 -> `icw3`=8'h04; `cur_MASK`=8'hF0 one cycle after WR_n rises; no `MASK_reset` pulse on OCW1.
- In READY with `cur_MASK`=8'hF0, read A0=1 -> `D_out`=8'hF0, `D_out_en`=1. Write OCW3=8'h0B, read A0=0 with `isr`=8'h05 -> `D_out`=8'h05. Write OCW3=8'h0A with `irr`=8'h81 -> `D_out`=8'h81.
- Write ICW1=8'h13 mid-sequence while in WAIT_ICW4 -> state WAIT_ICW2, `init_done`=0, `cur_MASK`=8'h00, one `MASK_reset` pulse.
- Assert rst_n=0 asynchronously between ICW2 and ICW4 -> all outputs return to reset values immediately; a following A0=1 write is ignored (state WAIT_ICW1).
- In READY, write OCW2=8'h20 with WR_n held high 5 cycles afterwards -> `ocw2_valid` high exactly 1 cycle, `ocw2_data`=8'h20; a write with CS_n=1 -> no state change.
